// File: rtl/regfile_writeback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_ctrl_if
// Description : Producer-side handshakes (ALU, load path) and the
//               register-file write port of the writeback controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_writeback_ctrl_if #(
    parameter int CW = 3
);
    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [4:0]    ld_rd;
    logic [31:0]   ld_data;
    logic [2:0]    ld_funct3;
    logic [1:0]    ld_addr_lo;
    logic          regWrite;
    logic [4:0]    writereg;
    logic [31:0]   writedata;
    logic [CW-1:0] wb_count;
    logic          wb_empty;

    // Producer / observer side
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
        input  alu_ready, ld_ready,
        input  regWrite, writereg, writedata, wb_count, wb_empty
    );

    // Writeback controller side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
        output alu_ready, ld_ready,
        output regWrite, writereg, writedata, wb_count, wb_empty
    );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_ctrl
// Description : Merges ALU results and formatted load data into a small
//               pending-write FIFO that drives one register-file write per
//               cycle. Load path has priority; x0 results are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  wire                      clk,
    input  wire                      rst,
    regfile_writeback_ctrl_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q,  wptr_d;
    logic [PW-1:0] rptr_q,  rptr_d;
    logic          regwrite_q, regwrite_d;
    logic [4:0]    writereg_q, writereg_d;
    logic [31:0]   writedata_q, writedata_d;
    logic [4:0]    rd_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic          full;
    logic          ld_fire, alu_fire;
    logic          enq, deq;
    logic [4:0]    enq_rd;
    logic [31:0]   enq_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_fmt;

    // Ready from registered occupancy only; load wins over ALU
    assign full          = (count_q == CW'(DEPTH));
    assign bus.ld_ready  = !full;
    assign bus.alu_ready = !full && !bus.ld_valid;
    assign ld_fire       = bus.ld_valid && !full;
    assign alu_fire      = bus.alu_valid && !full && !bus.ld_valid;
    assign deq           = (count_q != '0);

    // Byte/halfword extraction and sign/zero extension of the raw load word
    always_comb begin
        ld_byte = bus.ld_data[{bus.ld_addr_lo, 3'b000} +: 8];
        ld_half = bus.ld_addr_lo[1] ? bus.ld_data[31:16] : bus.ld_data[15:0];
        case (bus.ld_funct3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = bus.ld_data;
        endcase
    end

    // Select the accepted result; x0 destinations are accepted but not queued
    always_comb begin
        enq      = 1'b0;
        enq_rd   = 5'd0;
        enq_data = 32'd0;
        if (ld_fire) begin
            enq      = (bus.ld_rd != 5'd0);
            enq_rd   = bus.ld_rd;
            enq_data = ld_fmt;
        end else if (alu_fire) begin
            enq      = (bus.alu_rd != 5'd0);
            enq_rd   = bus.alu_rd;
            enq_data = bus.alu_data;
        end
    end

    // Next-state: pop the head into the write port, advance pointers, track count
    always_comb begin
        count_d     = count_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        regwrite_d  = 1'b0;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        if (deq) begin
            regwrite_d  = 1'b1;
            writereg_d  = rd_mem_q[rptr_q];
            writedata_d = data_mem_q[rptr_q];
            rptr_d      = rptr_q + 1'b1;
        end
        if (enq) begin
            wptr_d = wptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and write-port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            regwrite_q  <= 1'b0;
            writereg_q  <= 5'd0;
            writedata_q <= 32'd0;
        end else begin
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    // FIFO storage, written at the tail on enqueue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else if (enq) begin
            rd_mem_q[wptr_q]   <= enq_rd;
            data_mem_q[wptr_q] <= enq_data;
        end
    end

    assign bus.regWrite  = regwrite_q;
    assign bus.writereg  = writereg_q;
    assign bus.writedata = writedata_q;
    assign bus.wb_count  = count_q;
    assign bus.wb_empty  = (count_q == '0) && !regwrite_q;

endmodule
`default_nettype wire
